// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver: alternates ones/tens anodes each slot,
// blanks anodes briefly at slot start and swaps new digits in only at frame boundaries.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int GHOST_CYC   = 4,
    parameter int BLANK_LEAD  = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Load,
    input  logic [3:0] i_Tens,
    input  logic [3:0] i_Ones,
    output logic [6:0] o_Seg,
    output logic [1:0] o_An,
    output logic       o_Frame
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  GHOST_END = CW'(GHOST_CYC);
    localparam bit             BLANK_EN  = (BLANK_LEAD != 0);

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } scanStateT;

    scanStateT      stateR;
    logic [CW-1:0]  cntR;
    logic [3:0]     shadowTensR;
    logic [3:0]     shadowOnesR;
    logic           pendingR;
    logic [3:0]     dispTensR;
    logic [3:0]     dispOnesR;
    logic [6:0]     segR;
    logic [1:0]     anR;
    logic           frameR;

    logic           wrapS;
    logic           commitS;
    logic [6:0]     segNextS;
    logic [1:0]     anNextS;

    // Active-low segment pattern for one BCD digit; non-BCD codes show a dash.
    function automatic logic [6:0] decodeDigit(input logic [3:0] digit);
        case (digit)
            4'd0:    decodeDigit = 7'h40;
            4'd1:    decodeDigit = 7'h79;
            4'd2:    decodeDigit = 7'h24;
            4'd3:    decodeDigit = 7'h30;
            4'd4:    decodeDigit = 7'h19;
            4'd5:    decodeDigit = 7'h12;
            4'd6:    decodeDigit = 7'h02;
            4'd7:    decodeDigit = 7'h78;
            4'd8:    decodeDigit = 7'h00;
            4'd9:    decodeDigit = 7'h10;
            default: decodeDigit = 7'h3F;
        endcase
    endfunction

    assign wrapS   = (cntR == CNT_LAST);
    assign commitS = wrapS && (stateR == S_TENS);

    // Next segment/anode pattern from the current slot, position and display digits.
    always_comb begin
        segNextS = 7'h7F;
        anNextS  = 2'b11;
        if (cntR < GHOST_END) begin
            segNextS = 7'h7F;
            anNextS  = 2'b11;
        end else if (stateR == S_ONES) begin
            segNextS = decodeDigit(dispOnesR);
            anNextS  = 2'b10;
        end else if (BLANK_EN && (dispTensR == 4'd0)) begin
            segNextS = 7'h7F;
            anNextS  = 2'b11;
        end else begin
            segNextS = decodeDigit(dispTensR);
            anNextS  = 2'b01;
        end
    end

    // Slot counter, scan FSM, load shadowing with frame-boundary commit, output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cntR        <= {CW{1'b0}};
            stateR      <= S_ONES;
            shadowTensR <= 4'd0;
            shadowOnesR <= 4'd0;
            pendingR    <= 1'b0;
            dispTensR   <= 4'd0;
            dispOnesR   <= 4'd0;
            segR        <= 7'h7F;
            anR         <= 2'b11;
            frameR      <= 1'b0;
        end else begin
            cntR <= wrapS ? {CW{1'b0}} : cntR + CW'(1);
            if (wrapS) begin
                stateR <= (stateR == S_ONES) ? S_TENS : S_ONES;
            end else begin
                stateR <= stateR;
            end
            if (i_Load) begin
                shadowTensR <= i_Tens;
                shadowOnesR <= i_Ones;
            end
            // A load landing on the commit cycle is fresher than anything shadowed.
            if (commitS && i_Load) begin
                dispTensR <= i_Tens;
                dispOnesR <= i_Ones;
                pendingR  <= 1'b0;
            end else if (commitS && pendingR) begin
                dispTensR <= shadowTensR;
                dispOnesR <= shadowOnesR;
                pendingR  <= 1'b0;
            end else if (i_Load) begin
                pendingR  <= 1'b1;
            end
            segR   <= segNextS;
            anR    <= anNextS;
            frameR <= commitS;
        end
    end

    assign o_Seg   = segR;
    assign o_An    = anR;
    assign o_Frame = frameR;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model queues the
// expected outputs of every cycle; a monitor pops and compares them.
module tb_seg7_scan_driver;

    localparam int N = 8;
    localparam int G = 2;
    localparam logic [6:0] DIGIT_SEG [0:9] =
        '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic       frame;
    } expT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  expFrames = 0;
    int  gotFrames = 0;

    // Model state: cycles since reset release, shown digits, pending load.
    int t = 0;
    int dT = 0, dO = 0, pT = 0, pO = 0;
    bit pV = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(N), .GHOST_CYC(G), .BLANK_LEAD(1)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Tens(tens), .i_Ones(ones),
        .o_Seg(seg), .o_An(an), .o_Frame(frame)
    );

    function automatic logic [6:0] segOf(int d);
        if (d > 9) return 7'h3F;
        return DIGIT_SEG[d];
    endfunction

    // Reference model: compute what the display must show one cycle after this edge.
    always @(posedge clk) begin
        expT e;
        int  pos;
        int  slot;
        bit  boundary;
        if (rst) begin
            e = '{seg: 7'h7F, an: 2'b11, frame: 1'b0};
            t = 0; dT = 0; dO = 0; pT = 0; pO = 0; pV = 0;
        end else begin
            pos      = t % N;
            slot     = (t / N) % 2;
            boundary = (slot == 1) && (pos == N - 1);
            e.frame  = boundary;
            if (pos < G) begin
                e.seg = 7'h7F; e.an = 2'b11;
            end else if (slot == 0) begin
                e.seg = segOf(dO); e.an = 2'b10;
            end else if (dT == 0) begin
                e.seg = 7'h7F; e.an = 2'b11;
            end else begin
                e.seg = segOf(dT); e.an = 2'b01;
            end
            if (boundary) expFrames++;
            if (boundary && load) begin
                dT = int'(tens); dO = int'(ones); pV = 0;
            end else if (boundary && pV) begin
                dT = pT; dO = pO; pV = 0;
            end else if (load) begin
                pT = int'(tens); pO = int'(ones); pV = 1;
            end
            t++;
        end
        expQ.push_back(e);
    end

    // Monitor: sample just after the edge and compare against the oldest expectation.
    always @(posedge clk) begin
        expT e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (seg !== e.seg || an !== e.an || frame !== e.frame) begin
                errors++;
                $display("FAIL out @%0t: got seg=%h an=%b frame=%b, expected seg=%h an=%b frame=%b",
                         $time, seg, an, frame, e.seg, e.an, e.frame);
            end
            if (frame === 1'b1) gotFrames++;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ld(int tv, int ov);
        @(negedge clk);
        load = 1'b1; tens = 4'(tv); ones = 4'(ov);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Wait until the next edge is frame position r (bounded).
    task automatic alignTo(int r);
        for (int k = 0; k < 4 * N && (t % (2 * N)) != r; k++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc(20);
        ld(4, 2);
        cyc(40);
        ld(0, 7);
        cyc(40);
        ld(1, 12);
        cyc(40);
        alignTo(2);
        ld(3, 3);
        cyc(3);
        ld(5, 5);
        alignTo(2 * N - 1);
        load = 1'b1; tens = 4'd6; ones = 4'd8;
        @(negedge clk);
        load = 1'b0;
        cyc(40);
        alignTo(3);
        ld(9, 9);
        cyc(2);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(40);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 99) == 0);
            load = ($urandom_range(0, 3) == 0);
            tens = 4'($urandom_range(0, 15));
            ones = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        cyc(40);
        checks++;
        if (gotFrames != expFrames || expFrames == 0) begin
            errors++;
            $display("FAIL frame_count: got %0d pulses, expected %0d", gotFrames, expFrames);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal range >= 4).
REQ-002 SHALL have parameter GHOST_CYC, default 4, anode-off cycles at the start of each slot (legal range 0 to REFRESH_DIV-2).
REQ-003 SHALL have parameter BLANK_LEAD, default 1, where 1 blanks the tens digit when it equals 0.
REQ-004 SHALL have port i_Clk, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port i_Rst, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have port i_Load, input, 1 bit, a strobe that captures i_Tens and i_Ones.
REQ-007 SHALL have port i_Tens, input, 4 bits, the BCD tens digit from the binary-to-BCD stage.
REQ-008 SHALL have port i_Ones, input, 4 bits, the BCD ones digit from the binary-to-BCD stage.
REQ-009 SHALL have port o_Seg, output, 7 bits, active-low segments with bit0=a through bit6=g.
REQ-010 SHALL have port o_An, output, 2 bits, active-low anodes with bit0=ones and bit1=tens.
REQ-011 SHALL have port o_Frame, output, 1 bit, a one-cycle pulse per completed two-digit scan.

Function
REQ-012 SHALL hold a slot counter cnt, 0..REFRESH_DIV-1, incrementing every cycle and wrapping to 0.
REQ-013 SHALL implement a two-state FSM, S_ONES and S_TENS: at cnt==REFRESH_DIV-1, S_ONES goes to S_TENS and S_TENS goes to S_ONES; otherwise the state holds.
REQ-014 SHALL capture i_Tens/i_Ones into shadow registers and set a pending flag whenever i_Load=1; the last load in a frame wins.
REQ-015 SHALL commit the shadow registers to the display registers only on the S_TENS->S_ONES transition (frame boundary) when pending=1, clearing pending.
REQ-016 SHALL commit i_Tens/i_Ones directly to the display registers and leave pending=0 when i_Load=1 in the commit cycle, overriding any older shadow value.
REQ-017 SHALL register o_Seg, o_An and o_Frame, each reflecting the FSM state, cnt and display registers of the preceding cycle (1-cycle latency).
REQ-018 SHALL drive o_An=2'b11 and o_Seg=7'h7F while cnt<GHOST_CYC (anti-ghosting).
REQ-019 SHALL otherwise drive o_An=2'b10 in S_ONES and o_An=2'b01 in S_TENS.
REQ-020 SHALL drive o_An=2'b11 and o_Seg=7'h7F in S_TENS when BLANK_LEAD=1 and the tens display register equals 0.
REQ-021 SHALL decode digits as 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, active-low).
REQ-022 SHALL display codes 10-15 as dash 7'h3F (segment g only).
REQ-023 SHALL assert o_Frame for exactly one cycle, the cycle after S_TENS with cnt==REFRESH_DIV-1, giving a period of 2*REFRESH_DIV cycles.
REQ-024 SHALL raise the first o_Frame 2*REFRESH_DIV cycles after reset deasserts.

Reset
REQ-025 SHALL, on i_Rst=1 at a clock edge, set cnt=0, state=S_ONES, shadow=0, display=0 and pending=0.
REQ-026 SHALL, on the same edge, drive o_An=2'b11, o_Seg=7'h7F and o_Frame=0.
REQ-027 SHALL discard a pending load when reset is asserted mid-frame, and SHALL hold all reset values while i_Rst stays high.

Verification (REFRESH_DIV=8, GHOST_CYC=2, BLANK_LEAD=1)
REQ-028 SHALL be covered by test V1: i_Rst=1 for 3 cycles -> o_An=11, o_Seg=7F, o_Frame=0 throughout; after release, the first o_Frame pulse arrives 16 cycles later and repeats every 16 cycles.
REQ-029 SHALL be covered by test V2: load tens=4, ones=2 mid-frame -> no change until the frame boundary; then the ones slot shows An=10/Seg=24 for cycles 2-7 and the tens slot shows An=01/Seg=19.
REQ-030 SHALL be covered by test V3: load 0,7 -> ones slot shows Seg=78; tens slot shows An=11 and Seg=7F for the whole slot.
REQ-031 SHALL be covered by test V4: load tens=1, ones=12 -> ones slot shows Seg=3F (dash); tens slot shows Seg=79.
REQ-032 SHALL be covered by test V5: loads 3,3 then 5,5 in one frame, plus 6,8 in the commit cycle -> the next frame shows 6,8; values 3,3 and 5,5 never appear.
REQ-033 SHALL be covered by test V6: load 9,9, then assert i_Rst before the frame boundary -> after release, the ones slot shows Seg=40 and the tens slot is blanked; 9,9 never appears.
